// File: rtl/frogger_frog_ctrl.sv
`default_nettype none
// ============================================================================
// frogger_frog_ctrl : per-frame frog motion, log carry, death/respawn, scoring
// Rev 1.0
// ============================================================================
module frogger_frog_ctrl #(
  parameter int START_X      = 312,
  parameter int START_Y      = 464,
  parameter int GOAL_Y       = 16,
  parameter int MAX_X        = 623,
  parameter int MAX_Y        = 464,
  parameter int STEP         = 16,
  parameter int HOP_FRAMES   = 4,
  parameter int DEATH_FRAMES = 60,
  parameter int LIVES_INIT   = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       hit,
  input  logic       on_log,
  input  logic [3:0] log_dx,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       dead_flash
);

  typedef enum logic [2:0] {IDLE = 3'd0, HOP = 3'd1, DYING = 3'd2, GAMEOVER = 3'd3} state_t;
  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

  localparam int HCW = $clog2(HOP_FRAMES + 1);
  localparam int DCW = $clog2(DEATH_FRAMES);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] HSTEP_S = 11'(STEP / HOP_FRAMES);
  localparam logic signed [10:0] MAX_X_S = 11'(MAX_X);
  localparam logic signed [10:0] MAX_Y_S = 11'(MAX_Y);
  localparam logic signed [10:0] GOAL_S  = 11'(GOAL_Y);
  localparam logic [HCW-1:0] HOP_LAST   = HCW'(HOP_FRAMES);
  localparam logic [DCW-1:0] DEATH_LAST = DCW'(DEATH_FRAMES - 1);

  state_t         cur_state, nxt_state;
  dir_t           dir_q, nxt_dir, key_dir, step_dir;
  logic [9:0]     x_q, y_q, nxt_x, nxt_y;
  logic [1:0]     lives_q, nxt_lives;
  logic [7:0]     score_q, nxt_score, prev_key, nxt_prev;
  logic [HCW-1:0] hop_cnt, nxt_hop_cnt, hop_inc;
  logic [DCW-1:0] death_cnt, nxt_death_cnt;

  logic signed [10:0] cur_x, cur_y, drift_x, base_x, tgt_x, tgt_y, step_bx, step_x, step_y;
  logic key_is_dir, key_edge, drift_bad, tgt_ok;

  assign cur_x     = {1'b0, x_q};
  assign cur_y     = {1'b0, y_q};
  assign drift_x   = cur_x + {{7{log_dx[3]}}, log_dx};
  assign drift_bad = drift_x[10] || (drift_x > MAX_X_S);
  // A key arriving with drift is judged against the already-drifted x
  assign base_x    = on_log ? drift_x : cur_x;
  assign key_edge  = (keycode != prev_key);
  assign hop_inc   = hop_cnt + HCW'(1);
  assign step_dir  = (cur_state == HOP) ? dir_q : key_dir;
  assign step_bx   = (cur_state == HOP) ? cur_x : base_x;

  always_comb begin
    key_is_dir = 1'b1;
    key_dir    = D_UP;
    case (keycode)
      8'h1A:   key_dir = D_UP;
      8'h16:   key_dir = D_DOWN;
      8'h04:   key_dir = D_LEFT;
      8'h07:   key_dir = D_RIGHT;
      default: key_is_dir = 1'b0;
    endcase
  end

  always_comb begin
    tgt_x  = base_x;
    tgt_y  = cur_y;
    step_x = step_bx;
    step_y = cur_y;
    case (key_dir)
      D_UP:    tgt_y = cur_y - STEP_S;
      D_DOWN:  tgt_y = cur_y + STEP_S;
      D_LEFT:  tgt_x = base_x - STEP_S;
      default: tgt_x = base_x + STEP_S;
    endcase
    case (step_dir)
      D_UP:    step_y = cur_y - HSTEP_S;
      D_DOWN:  step_y = cur_y + HSTEP_S;
      D_LEFT:  step_x = step_bx - HSTEP_S;
      default: step_x = step_bx + HSTEP_S;
    endcase
  end

  assign tgt_ok = !tgt_x[10] && (tgt_x <= MAX_X_S) && (tgt_y >= GOAL_S) && (tgt_y <= MAX_Y_S);

  always_comb begin
    nxt_state     = cur_state;
    nxt_dir       = dir_q;
    nxt_x         = x_q;
    nxt_y         = y_q;
    nxt_lives     = lives_q;
    nxt_score     = score_q;
    nxt_prev      = prev_key;
    nxt_hop_cnt   = hop_cnt;
    nxt_death_cnt = death_cnt;
    if (frame_tick) begin
      nxt_prev = keycode;
      case (cur_state)
        IDLE: begin
          if (hit) begin
            nxt_state     = DYING;
            nxt_death_cnt = '0;
          end else if (on_log && drift_bad) begin
            nxt_state     = DYING;
            nxt_death_cnt = '0;
          end else begin
            nxt_x = base_x[9:0];
            // The accepting tick already performs the first hop step
            if (key_edge && key_is_dir && tgt_ok) begin
              nxt_state   = HOP;
              nxt_dir     = key_dir;
              nxt_x       = step_x[9:0];
              nxt_y       = step_y[9:0];
              nxt_hop_cnt = HCW'(1);
            end
          end
        end
        HOP: begin
          if (hit) begin
            nxt_state     = DYING;
            nxt_death_cnt = '0;
            nxt_hop_cnt   = '0;
          end else begin
            nxt_x       = step_x[9:0];
            nxt_y       = step_y[9:0];
            nxt_hop_cnt = hop_inc;
            if (hop_inc == HOP_LAST) begin
              nxt_state   = IDLE;
              nxt_hop_cnt = '0;
              if (step_y == GOAL_S) begin
                nxt_score = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                nxt_x     = 10'(START_X);
                nxt_y     = 10'(START_Y);
              end
            end
          end
        end
        DYING: begin
          if (death_cnt == DEATH_LAST) begin
            nxt_death_cnt = '0;
            nxt_lives     = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              nxt_state = GAMEOVER;
            end else begin
              nxt_state = IDLE;
              nxt_x     = 10'(START_X);
              nxt_y     = 10'(START_Y);
            end
          end else begin
            nxt_death_cnt = death_cnt + DCW'(1);
          end
        end
        GAMEOVER: begin
          if (key_edge && (keycode == 8'h28)) begin
            nxt_state = IDLE;
            nxt_lives = 2'(LIVES_INIT);
            nxt_score = '0;
            nxt_x     = 10'(START_X);
            nxt_y     = 10'(START_Y);
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_state <= IDLE;
      dir_q     <= D_UP;
      x_q       <= 10'(START_X);
      y_q       <= 10'(START_Y);
      lives_q   <= 2'(LIVES_INIT);
      score_q   <= '0;
      prev_key  <= '0;
      hop_cnt   <= '0;
      death_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      dir_q     <= nxt_dir;
      x_q       <= nxt_x;
      y_q       <= nxt_y;
      lives_q   <= nxt_lives;
      score_q   <= nxt_score;
      prev_key  <= nxt_prev;
      hop_cnt   <= nxt_hop_cnt;
      death_cnt <= nxt_death_cnt;
    end
  end

  assign frog_x     = x_q;
  assign frog_y     = y_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign state      = cur_state;
  assign dead_flash = (cur_state == DYING);

endmodule
`default_nettype wire

// File: tb/tb_frogger_frog_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frogger_frog_ctrl : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ============================================================================
module tb_frogger_frog_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       hit = 1'b0;
  logic       on_log = 1'b0;
  logic [3:0] log_dx = 4'h0;
  logic [9:0] frog_x, frog_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;
  logic       dead_flash;

  int errors = 0;
  int checks = 0;

  frogger_frog_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
    .hit(hit), .on_log(on_log), .log_dx(log_dx), .frog_x(frog_x), .frog_y(frog_y),
    .lives(lives), .score(score), .state(state), .dead_flash(dead_flash)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] key;
    logic       hit;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [2:0] est;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int ex, input int ey, input int est,
                           input int el, input int esc);
    check({name, ".x"}, frog_x, ex);
    check({name, ".y"}, frog_y, ey);
    check({name, ".state"}, state, est);
    check({name, ".lives"}, lives, el);
    check({name, ".score"}, score, esc);
    check({name, ".flash"}, dead_flash, (est == 2) ? 1 : 0);
  endtask

  task automatic tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
  endtask

  task automatic hop_up();
    keycode = 8'h1A; tick();
    keycode = 8'h00; tick(); tick(); tick();
  endtask

  // Ticks through a full death: stays DYING for 59 ticks, leaves on the 60th
  task automatic finish_death(input string name);
    for (int i = 0; i < 59; i++) begin
      hit = i[0];
      keycode = i[1] ? 8'h1A : 8'h00;
      tick();
    end
    hit = 1'b0; keycode = 8'h00;
    check({name, ".still_dying"}, state, 2);
    tick();
  endtask

  initial begin
    vecs[0]  = '{8'h1A, 1'b0, 10'd312, 10'd460, 3'd1};
    vecs[1]  = '{8'h1A, 1'b0, 10'd312, 10'd456, 3'd1};
    vecs[2]  = '{8'h1A, 1'b0, 10'd312, 10'd452, 3'd1};
    vecs[3]  = '{8'h1A, 1'b0, 10'd312, 10'd448, 3'd0};
    vecs[4]  = '{8'h1A, 1'b0, 10'd312, 10'd448, 3'd0};
    vecs[5]  = '{8'h1A, 1'b0, 10'd312, 10'd448, 3'd0};
    vecs[6]  = '{8'h16, 1'b0, 10'd312, 10'd452, 3'd1};
    vecs[7]  = '{8'h16, 1'b0, 10'd312, 10'd456, 3'd1};
    vecs[8]  = '{8'h16, 1'b0, 10'd312, 10'd460, 3'd1};
    vecs[9]  = '{8'h16, 1'b0, 10'd312, 10'd464, 3'd0};
    vecs[10] = '{8'h00, 1'b0, 10'd312, 10'd464, 3'd0};
    vecs[11] = '{8'h16, 1'b0, 10'd312, 10'd464, 3'd0};
    vecs[12] = '{8'h07, 1'b0, 10'd316, 10'd464, 3'd1};
    vecs[13] = '{8'h07, 1'b0, 10'd320, 10'd464, 3'd1};
    vecs[14] = '{8'h00, 1'b0, 10'd324, 10'd464, 3'd1};
    vecs[15] = '{8'h04, 1'b0, 10'd328, 10'd464, 3'd0};
    vecs[16] = '{8'h04, 1'b0, 10'd328, 10'd464, 3'd0};
    vecs[17] = '{8'h00, 1'b0, 10'd328, 10'd464, 3'd0};
    vecs[18] = '{8'h04, 1'b0, 10'd324, 10'd464, 3'd1};
    vecs[19] = '{8'h00, 1'b0, 10'd320, 10'd464, 3'd1};
    vecs[20] = '{8'h00, 1'b0, 10'd316, 10'd464, 3'd1};
    vecs[21] = '{8'h00, 1'b0, 10'd312, 10'd464, 3'd0};
    vecs[22] = '{8'h00, 1'b1, 10'd312, 10'd464, 3'd2};

    // Reset values
    #12;
    check_all("reset", 312, 464, 0, 3, 0);
    @(negedge Clk) Reset_n = 1'b1;

    // Hops, held keys, out-of-range hop, first death
    foreach (vecs[i]) begin
      keycode = vecs[i].key;
      hit     = vecs[i].hit;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].est, 3, 0);
    end
    hit = 1'b0; keycode = 8'h00;
    finish_death("death1");
    check_all("after_death1", 312, 464, 0, 2, 0);

    // Drift to the left edge, then a left key that would leave the field
    on_log = 1'b1; log_dx = 4'h8;
    for (int i = 0; i < 39; i++) tick();
    check_all("at_x0", 0, 464, 0, 2, 0);
    on_log = 1'b0; keycode = 8'h04; tick();
    check_all("left_at_x0", 0, 464, 0, 2, 0);
    keycode = 8'h07;
    repeat (3) @(negedge Clk);
    check_all("hold_no_tick", 0, 464, 0, 2, 0);
    keycode = 8'h00; tick();

    // Drift to x=620, then off the right edge
    on_log = 1'b1; log_dx = 4'h7;
    for (int i = 0; i < 88; i++) tick();
    log_dx = 4'h4; tick();
    check_all("at_x620", 620, 464, 0, 2, 0);
    tick();
    check_all("drift_off_right", 620, 464, 2, 2, 0);
    on_log = 1'b0; log_dx = 4'h0;
    finish_death("death2");
    check_all("after_death2", 312, 464, 0, 1, 0);

    // Goal scoring
    for (int i = 0; i < 27; i++) hop_up();
    check_all("at_y32", 312, 32, 0, 1, 0);
    hop_up();
    check_all("goal", 312, 464, 0, 1, 1);

    // Hit on the final hop tick: no score, last death -> game over
    for (int i = 0; i < 27; i++) hop_up();
    keycode = 8'h1A; tick();
    keycode = 8'h00; tick(); tick();
    hit = 1'b1; tick(); hit = 1'b0;
    check_all("hit_last_hop", 312, 20, 2, 1, 1);
    finish_death("death3");
    check_all("gameover", 312, 20, 3, 0, 1);
    keycode = 8'h1A; tick();
    check_all("gameover_frozen", 312, 20, 3, 0, 1);
    keycode = 8'h00; tick();
    keycode = 8'h28; tick();
    check_all("restart", 312, 464, 0, 3, 0);
    tick();
    check_all("restart_held", 312, 464, 0, 3, 0);

    // Drift and right key on the same tick
    keycode = 8'h00; on_log = 1'b1; log_dx = 4'h8;
    for (int i = 0; i < 26; i++) tick();
    log_dx = 4'hC; tick();
    check_all("at_x100", 100, 464, 0, 3, 0);
    log_dx = 4'hE; keycode = 8'h07; tick();
    check("drift_key.state", state, 1);
    keycode = 8'h00;
    tick(); tick(); tick();
    check_all("drift_hop_end", 114, 464, 0, 3, 0);
    on_log = 1'b0; log_dx = 4'h0;

    // Asynchronous reset in the middle of a hop
    keycode = 8'h1A; tick();
    keycode = 8'h00; tick();
    check_all("pre_reset", 114, 456, 1, 3, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_all("async_reset", 312, 464, 0, 3, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check_all("post_reset_idle", 312, 464, 0, 3, 0);
    keycode = 8'h1A; tick();
    check_all("post_reset_hop", 312, 460, 1, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
